// File: rtl/div_pkg.sv
// Shared types and default widths for the 25-by-9 sequential divider.
package div_pkg;

  localparam int unsigned MD_WD   = 16;
  localparam int unsigned MR_WD   = 9;
  localparam int unsigned MDMR_WD = MD_WD + MR_WD;

  // Iteration counter width, sized for the quotient bit index
  localparam int unsigned CNT_WD  = $clog2(MD_WD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division iteration: shift in one dividend bit and
// subtract the divisor when it fits. Purely combinational.
module div_step #(
  parameter int unsigned MR_WD = 9
) (
  input  logic [MR_WD-1:0] p_in,
  input  logic             bit_in,
  input  logic [MR_WD-1:0] d_in,
  output logic [MR_WD-1:0] p_out,
  output logic             q_bit
);

  logic [MR_WD:0] trial;
  logic [MR_WD:0] diff;

  // p_in < d_in is guaranteed by the caller, so trial < 2*d_in and the
  // difference always fits back into MR_WD bits.
  always_comb begin
    trial = {p_in, bit_in};
    diff  = trial - {1'b0, d_in};
    if (trial >= {1'b0, d_in}) begin
      p_out = diff[MR_WD-1:0];
      q_bit = 1'b1;
    end else begin
      p_out = trial[MR_WD-1:0];
      q_bit = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/div25by9_seq.sv
// Sequential radix-2 restoring divider: 25-bit dividend / 9-bit divisor
// yielding a 16-bit quotient and 9-bit remainder, one quotient bit per clock,
// with valid/ready handshakes on input and output.
module div25by9_seq #(
  parameter int unsigned MD_WD = div_pkg::MD_WD,
  parameter int unsigned MR_WD = div_pkg::MR_WD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MD_WD+MR_WD-1:0] dividend,
  input  logic [MR_WD-1:0]       divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MD_WD-1:0]       quotient,
  output logic [MR_WD-1:0]       remainder,
  output logic                   err_div0,
  output logic                   err_ovf
);

  import div_pkg::*;

  localparam int unsigned MDMR_WD = MD_WD + MR_WD;
  localparam int unsigned CTR_WD  = (MD_WD > 1) ? $clog2(MD_WD) : 1;

  state_e              state_q, state_d;
  logic [MD_WD-1:0]    nlo_q, nlo_d;        // low dividend bits, consumed MSB first
  logic [MR_WD-1:0]    d_q, d_d;            // latched divisor
  logic [MR_WD-1:0]    p_q, p_d;            // partial remainder
  logic [CTR_WD-1:0]   i_q, i_d;            // current quotient bit index
  logic [MD_WD-1:0]    qacc_q, qacc_d;      // quotient being assembled
  logic [MD_WD-1:0]    quotient_q, quotient_d;
  logic [MR_WD-1:0]    remainder_q, remainder_d;
  logic                err_div0_q, err_div0_d;
  logic                err_ovf_q, err_ovf_d;

  logic [MR_WD-1:0]    hi_part;
  logic [MR_WD-1:0]    step_p;
  logic                step_q;

  assign hi_part = dividend[MDMR_WD-1:MD_WD];

  div_step #(
    .MR_WD (MR_WD)
  ) u_step (
    .p_in   (p_q),
    .bit_in (nlo_q[i_q]),
    .d_in   (d_q),
    .p_out  (step_p),
    .q_bit  (step_q)
  );

  // Next-state and datapath updates for the IDLE/CALC/DONE sequence
  always_comb begin
    state_d     = state_q;
    nlo_d       = nlo_q;
    d_d         = d_q;
    p_d         = p_q;
    i_d         = i_q;
    qacc_d      = qacc_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    err_div0_d  = err_div0_q;
    err_ovf_d   = err_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          nlo_d = dividend[MD_WD-1:0];
          d_d   = divisor;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend[MR_WD-1:0];
            err_div0_d  = 1'b1;
            err_ovf_d   = 1'b0;
            state_d     = DONE;
          end else if (hi_part >= divisor) begin
            // Upper dividend bits already reach D: quotient needs > MD_WD bits
            quotient_d  = '1;
            remainder_d = '0;
            err_div0_d  = 1'b0;
            err_ovf_d   = 1'b1;
            state_d     = DONE;
          end else begin
            p_d     = hi_part;
            i_d     = CTR_WD'(MD_WD - 1);
            qacc_d  = '0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        p_d    = step_p;
        // Quotient bits emerge MSB first, so shifting left places them correctly
        qacc_d = {qacc_q[MD_WD-2:0], step_q};
        if (i_q == '0) begin
          quotient_d  = {qacc_q[MD_WD-2:0], step_q};
          remainder_d = step_p;
          err_div0_d  = 1'b0;
          err_ovf_d   = 1'b0;
          state_d     = DONE;
        end else begin
          i_d = i_q - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nlo_q       <= '0;
      d_q         <= '0;
      p_q         <= '0;
      i_q         <= '0;
      qacc_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      err_div0_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nlo_q       <= nlo_d;
      d_q         <= d_d;
      p_q         <= p_d;
      i_q         <= i_d;
      qacc_q      <= qacc_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      err_div0_q  <= err_div0_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign err_div0  = err_div0_q;
  assign err_ovf   = err_ovf_q;

endmodule : div25by9_seq

// File: tb/tb_div25by9_seq.sv
// Self-checking bench for div25by9_seq: directed vector table, handshake
// corner sequences, and random operations against an arithmetic model.
module tb_div25by9_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] dividend;
  logic [8:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [8:0]  remainder;
  logic        err_div0;
  logic        err_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div25by9_seq #(
    .MD_WD (16),
    .MR_WD (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err_div0  (err_div0),
    .err_ovf   (err_ovf)
  );

  typedef struct {
    logic [24:0] n;
    logic [8:0]  d;
    logic [15:0] q;
    logic [8:0]  r;
    logic        e0;
    logic        e1;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: quotient/remainder from plain integer division
  task automatic model(input logic [24:0] n, input logic [8:0] d,
                       output logic [15:0] q, output logic [8:0] r,
                       output logic e0, output logic e1, output int lat);
    int unsigned nn, dd, quo;
    nn = 32'(n);
    dd = 32'(d);
    if (dd == 0) begin
      q = 16'hFFFF; r = 9'(nn % 512); e0 = 1'b1; e1 = 1'b0; lat = 1;
    end else begin
      quo = nn / dd;
      if (quo > 65535) begin
        q = 16'hFFFF; r = '0; e0 = 1'b0; e1 = 1'b1; lat = 1;
      end else begin
        q = 16'(quo); r = 9'(nn % dd); e0 = 1'b0; e1 = 1'b0; lat = 17;
      end
    end
  endtask

  // Issue one operation. lat counts clock edges from the accepting edge
  // (inclusive) until out_valid is seen. hold = cycles of out_ready=0 in DONE.
  task automatic run_op(input logic [24:0] n, input logic [8:0] d, input int hold,
                        output logic [15:0] q, output logic [8:0] r,
                        output logic e0, output logic e1, output int lat);
    int guard;
    logic stable;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands must already be latched; scramble the bus
    dividend = 25'($urandom);
    divisor  = 9'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    e0 = err_div0;
    e1 = err_ovf;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!out_valid || in_ready || quotient !== q || remainder !== r ||
            err_div0 !== e0 || err_ovf !== e1) stable = 1'b0;
      end
      chk("backpressure_hold_stable", 32'(stable), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_out_valid_drop", 32'(out_valid), 32'd0);
    chk("consume_in_ready_rise", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] q, eq;
    logic [8:0]  r, er;
    logic        e0, e1, ee0, ee1;
    int          lat, elat;
    logic [24:0] n;
    logic [8:0]  d;
    logic        quiet;

    vecs[0] = '{n: 25'd19628000, d: 9'd500, q: 16'd39256, r: 9'd0,   e0: 1'b0, e1: 1'b0, lat: 17};
    vecs[1] = '{n: 25'd19628123, d: 9'd500, q: 16'd39256, r: 9'd123, e0: 1'b0, e1: 1'b0, lat: 17};
    vecs[2] = '{n: 25'd33488895, d: 9'd511, q: 16'd65535, r: 9'd510, e0: 1'b0, e1: 1'b0, lat: 17};
    vecs[3] = '{n: 25'd32768000, d: 9'd500, q: 16'd65535, r: 9'd0,   e0: 1'b0, e1: 1'b1, lat: 1};
    vecs[4] = '{n: 25'd1234,     d: 9'd0,   q: 16'd65535, r: 9'd210, e0: 1'b1, e1: 1'b0, lat: 1};
    vecs[5] = '{n: 25'd0,        d: 9'd1,   q: 16'd0,     r: 9'd0,   e0: 1'b0, e1: 1'b0, lat: 17};
    vecs[6] = '{n: 25'd65535,    d: 9'd1,   q: 16'd65535, r: 9'd0,   e0: 1'b0, e1: 1'b0, lat: 17};
    vecs[7] = '{n: 25'd65536,    d: 9'd1,   q: 16'd65535, r: 9'd0,   e0: 1'b0, e1: 1'b1, lat: 1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_flags", {30'd0, err_div0, err_ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].n, vecs[i].d, 0, q, r, e0, e1, lat);
      chk($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_err_div0", i), 32'(e0), 32'(vecs[i].e0));
      chk($sformatf("vec%0d_err_ovf", i), 32'(e1), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: hold out_ready low for 5 cycles in DONE
    run_op(25'd19628123, 9'd500, 5, q, r, e0, e1, lat);
    chk("bp_quotient", 32'(q), 32'd39256);
    chk("bp_remainder", 32'(r), 32'd123);

    // Reset during CALC cycle 8 drops the operation
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 25'd19628000;
    divisor = 9'd500;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    chk("midreset_quotient", 32'(quotient), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) quiet = 1'b0;
    end
    chk("midreset_no_stale_result", 32'(quiet), 32'd1);

    run_op(25'd1000, 9'd7, 0, q, r, e0, e1, lat);
    chk("post_reset_quotient", 32'(q), 32'd142);
    chk("post_reset_remainder", 32'(r), 32'd6);
    chk("post_reset_latency", 32'(lat), 32'd17);

    // Random operations against the arithmetic model
    for (int k = 0; k < 200; k++) begin
      d = 9'($urandom_range(0, 511));
      n = 25'($urandom);
      if (k % 16 == 0) d = '0;
      else if (d != 0 && (k % 4 != 0)) n = 25'(32'(n) % (32'(d) << 16));
      model(n, d, eq, er, ee0, ee1, elat);
      run_op(n, d, (k % 10 == 0) ? 2 : 0, q, r, e0, e1, lat);
      chk($sformatf("rand%0d_quotient n=%0d d=%0d", k, n, d), 32'(q), 32'(eq));
      chk($sformatf("rand%0d_remainder n=%0d d=%0d", k, n, d), 32'(r), 32'(er));
      chk($sformatf("rand%0d_flags", k), {30'd0, e0, e1}, {30'd0, ee0, ee1});
      chk($sformatf("rand%0d_latency", k), 32'(lat), 32'(elat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div25by9_seq
